dff_univ_reg: RTL
=================

Name: dff_univ_reg

Overview:
- Parametrised successor to the team's 2-bit synchronous set/clear flip-flop.
- WIDTH-bit universal register: hold, parallel load, shift, rotate, increment and decrement modes.
- Adds asynchronous active-low clear, synchronous active-low set to a programmable value, clock enable, serial I/O and wrap (terminal-count) flag.
- Used as the general state/shift/count register in datapath and controller blocks.

Parameters:
- WIDTH, 8, register width in bits (legal range 2 to 32).
- SET_VAL, all ones ({WIDTH{1'b1}}), value loaded by synchronous set.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low clear; highest priority.
- set  input  1  synchronous active-low set; loads SET_VAL.
- en  input  1  active-high clock enable for mode operations.
- mode  input  3  operation select (see Behaviour).
- d  input  WIDTH  parallel load data.
- si  input  1  serial input for shift operations.
- q  output  WIDTH  register contents.
- so  output  1  registered bit most recently shifted or rotated out.
- tc  output  1  registered wrap flag from the previous cycle's count operation.
- zero  output  1  combinational; high when q equals 0.

Behaviour:
- Reset: clr low forces q=0, so=0 and tc=0 immediately, independent of clk. While clr is low, edges are ignored.
- First edge after clr deasserts is a normal edge.
- Priority at each rising clk edge, with clr high:
  1. set==0: q<=SET_VAL, so<=0, tc<=0. Applies regardless of en and mode.
  2. en==0: q and so hold; tc<=0.
  3. en==1: operation selected by mode, below.
- Mode operations:
  - 000 hold: q and so hold; tc<=0.
  - 001 load: q<=d; so holds; tc<=0.
  - 010 shift left: q<={q[WIDTH-2:0],si}; so<=q[WIDTH-1]; tc<=0.
  - 011 shift right: q<={si,q[WIDTH-1:1]}; so<=q[0]; tc<=0.
  - 100 rotate left: q<={q[WIDTH-2:0],q[WIDTH-1]}; so<=q[WIDTH-1]; tc<=0.
  - 101 rotate right: q<={q[0],q[WIDTH-1:1]}; so<=q[0]; tc<=0.
  - 110 increment: q<=q+1 modulo 2^WIDTH; so holds. tc<=1 only when old q was all ones (wrap to 0), else 0.
  - 111 decrement: q<=q-1 modulo 2^WIDTH; so holds. tc<=1 only when old q was 0 (wrap to all ones), else 0.
- tc is a single-cycle pulse:
  - High for exactly the cycle after a wrapping edge.
  - Continuous wrapping counts in WIDTH=2 give consecutive pulses only at actual wraps.
- Latency:
  - q, so and tc change one edge after inputs are sampled.
  - zero follows q combinationally, with no added cycle.
- Outputs never take X or Z values. All bits are driven 0/1 at all times after clr.
- Arithmetic is unsigned and WIDTH bits wide. The carry/borrow is reported only through tc, never stored in q.
- Boundary conditions:
  - Simultaneous set low and mode=load: set wins, q=SET_VAL.
  - clr asserted mid-count: q=0 immediately. The count resumes from 0 after release.
  - clr and set low together: clr wins.
  - Once released, set low on the next edge gives SET_VAL.

Test Plan (WIDTH=8, SET_VAL=8'hFF unless noted):
- clr low for 2 cycles, then high: q=8'h00, so=0, tc=0, zero=1. Pulse clr low between edges while q=8'h5A: q=8'h00 with no clock edge.
- en=1, mode=001, d=8'hA5, then set=0 with mode=001, d=8'h3C: q=8'hA5, then q=8'hFF; so=0, tc=0.
- Load 8'h81, then mode=010 with si=0 twice: q=8'h02 with so=1, then q=8'h04 with so=0. Next, mode=101: q=8'h02, so=0.
- Load 8'hFE, then mode=110 for 3 edges: q sequence FF, 00, 01. tc=1 only in the cycle with q=00; zero=1 in that same cycle.
- Load 8'h01, then mode=111 for 2 edges: q=00 with tc=0, then q=FF with tc=1. Then en=0 for one edge: q holds FF, tc=0.
- WIDTH=4, SET_VAL=4'h9: set=0 gives q=4'h9. Then increment 7 edges: q=0 with tc=1 after the 7th edge.

Source files
------------

// File: rtl/dff_univ_reg.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, increment, decrement with serial I/O.
// Latency: q/so/tc update one clk edge after inputs are sampled; zero follows q combinationally.
// Backpressure: none; en gates mode operations, set overrides en/mode, clr overrides everything asynchronously.
module dff_univ_reg #(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_INC  = 3'b110,
        MODE_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic             tc_q, tc_d;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // Next-state selection: set beats enable, enable gates the mode operation; tc is a one-cycle pulse.
    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        tc_d = 1'b0;
        if (!set) begin
            q_d  = SET_VAL;
            so_d = 1'b0;
        end else if (en) begin
            case (mode_sel)
                MODE_HOLD: begin
                    q_d = q_q;
                end
                MODE_LOAD: begin
                    q_d = d;
                end
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], si};
                    so_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d  = {si, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                MODE_ROR: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_INC: begin
                    // Carry out is reported only through tc; q wraps modulo 2^WIDTH.
                    q_d  = q_q + ONE;
                    tc_d = (q_q == ALL_ONES);
                end
                MODE_DEC: begin
                    // Borrow out is reported only through tc; q wraps modulo 2^WIDTH.
                    q_d  = q_q - ONE;
                    tc_d = (q_q == '0);
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear taking priority over every edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q  <= '0;
            so_q <= 1'b0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
            tc_q <= tc_d;
        end
    end

    assign q    = q_q;
    assign so   = so_q;
    assign tc   = tc_q;
    assign zero = (q_q == '0);

endmodule
